hls_deadlock_multi_monitor: RTL

- Parametrised deadlock monitor for HLS dataflow regions. It watches N_AXIS AXI-Stream block signals and N_INST process idle/block signal pairs.
- It asserts `block` only after a stall condition has persisted for HOLD_CYCLES consecutive cycles.
- It captures a sticky flag, a first-stall source snapshot and a saturating count of stall episodes, for debug readout.
- It sits beside the merger's dataflow instances and feeds the top-level deadlock/debug status.

---
 rtl/hls_deadlock_multi_monitor.sv | 59 +++++
 1 files changed

// File: rtl/hls_deadlock_multi_monitor.sv
// hls_deadlock_multi_monitor: qualified deadlock detector for HLS dataflow regions with sticky debug capture
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   enable, clear         : monitor enable; synchronous clear of sticky/snapshot/counter
//   axis_block_sigs       : per-stream blocked flags
//   inst_idle_sigs/_block : per-instance idle and blocked flags
//   block                 : stall persisted HOLD_CYCLES edges
//   block_sticky          : set on first block rise, held until clear
//   first_src             : {inst_block_sigs, axis_block_sigs} captured at the first rise
//   episode_count         : saturating count of block rises
module hls_deadlock_multi_monitor #(
  parameter int N_AXIS = 4,
  parameter int N_INST = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_INST-1:0]        inst_idle_sigs,
  input  logic [N_INST-1:0]        inst_block_sigs,
  output logic                     block,
  output logic                     block_sticky,
  output logic [N_INST+N_AXIS-1:0] first_src,
  output logic [CNT_W-1:0]         episode_count
);
  localparam int PW = $clog2(HOLD_CYCLES + 1);
  logic [PW-1:0] pcnt;
  logic raw, block_nxt, rise;
  // an instance stall needs every process idle or blocked with at least one blocked; all-idle is a clean finish
  always_comb begin
    raw = enable & ((|axis_block_sigs) | ((&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs)));
    block_nxt = raw & (pcnt >= PW'(HOLD_CYCLES - 1));
    rise = block_nxt & ~block;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      block <= 1'b0;
      block_sticky <= 1'b0;
      first_src <= '0;
      episode_count <= '0;
    end else begin
      pcnt <= !raw ? '0 : (pcnt == PW'(HOLD_CYCLES)) ? pcnt : pcnt + 1'b1;
      block <= block_nxt;
      // clear wins over a coincident rise for the debug registers only
      if (clear) begin
        block_sticky <= 1'b0;
        first_src <= '0;
        episode_count <= '0;
      end else if (rise) begin
        block_sticky <= 1'b1;
        if (!block_sticky) first_src <= {inst_block_sigs, axis_block_sigs};
        if (episode_count != '1) episode_count <= episode_count + 1'b1;
      end
    end
  end
endmodule
